// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers and a start/busy/done handshake.
// Optional MDU_FAST_MULT_EN: mult/multu use one combinational multiply and finish in one edge.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] work_reg;
  logic [WIDTH-1:0]   opnd_reg;
  logic               is_div_reg;
  logic               neg_res_reg;
  logic               neg_rem_reg;
  logic               dz_reg;
  logic               done_reg;
  logic               div0_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;

  logic               signed_op;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign signed_op = ~op[0];
  assign a_abs     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_abs     = (signed_op && b[WIDTH-1]) ? -b : b;

  // Multiply: work = {partial sum, remaining multiplier bits}; the carry lands in the top bit on shift.
  assign mul_sum  = {1'b0, work_reg[2*WIDTH-1:WIDTH]} + {1'b0, opnd_reg};
  // Divide: work = {remainder, dividend/quotient}; the remainder stays below 2*divisor so WIDTH+1 bits suffice.
  assign rem_sh   = {work_reg[2*WIDTH-1:WIDTH], work_reg[WIDTH-1]};
  assign div_diff = rem_sh - {1'b0, opnd_reg};
  assign quo      = work_reg[WIDTH-1:0];
  assign rem      = work_reg[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      work_reg    <= '0;
      opnd_reg    <= '0;
      is_div_reg  <= 1'b0;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      dz_reg      <= 1'b0;
      done_reg    <= 1'b0;
      div0_reg    <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            case (op)
              3'b100: begin
                hi_reg   <= a;
                div0_reg <= 1'b0;
              end
              3'b101: begin
                lo_reg   <= a;
                div0_reg <= 1'b0;
              end
              3'b000, 3'b001, 3'b010, 3'b011: begin
                div0_reg    <= 1'b0;
                cnt_reg     <= '0;
                is_div_reg  <= op[1];
                neg_res_reg <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_rem_reg <= signed_op & a[WIDTH-1];
                if (op[1]) begin
                  work_reg <= {{WIDTH{1'b0}}, a_abs};
                  opnd_reg <= b_abs;
                  dz_reg   <= (b == '0);
                  state_reg <= (b == '0) ? FIX : CALC;
                end else begin
                  dz_reg   <= 1'b0;
                  opnd_reg <= a_abs;
`ifdef MDU_FAST_MULT_EN
                  work_reg  <= {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
                  state_reg <= FIX;
`else
                  work_reg  <= {{WIDTH{1'b0}}, b_abs};
                  state_reg <= CALC;
`endif
                end
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (is_div_reg) begin
            if (!div_diff[WIDTH])
              work_reg <= {div_diff[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b1};
            else
              work_reg <= {rem_sh[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b0};
          end else if (work_reg[0]) begin
            work_reg <= {mul_sum, work_reg[WIDTH-1:1]};
          end else begin
            work_reg <= {1'b0, work_reg[2*WIDTH-1:1]};
          end
          if (cnt_reg == CNT_W'(WIDTH - 1))
            state_reg <= FIX;
        end
        FIX: begin
          if (dz_reg) begin
            div0_reg <= 1'b1;
          end else if (is_div_reg) begin
            lo_reg <= neg_res_reg ? -quo : quo;
            hi_reg <= neg_rem_reg ? -rem : rem;
          end else begin
            {hi_reg, lo_reg} <= neg_res_reg ? -work_reg : work_reg;
          end
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = done_reg;
  assign div0 = div0_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (WIDTH=32), one task per scenario.
module tb_mdu_iter;
  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;

`ifdef MDU_FAST_MULT_EN
  localparam int MUL_EDGES = 1;
`else
  localparam int MUL_EDGES = 33;
`endif

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents a request for one rising edge (E0); returns #1 after E0.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done with a bounded number of edges; edges = count of edges after E0.
  task automatic wait_done(output int edges);
    edges = 0;
    while (done !== 1'b1 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, div0} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b div0=%b hi=%h lo=%h, want all 0", busy, done, div0, hi, lo);
    end
    @(negedge clk); rst = 1'b0;
    $display("reset: busy=%b done=%b div0=%b hi=%h lo=%h", busy, done, div0, hi, lo);
  endtask

  task automatic test_mult;
    int e;
    issue(3'b000, 32'hFFFFFFFD, 32'h00000005);
    wait_done(e);
    checks++;
    if (e !== MUL_EDGES) begin
      errors++; $display("FAIL mult_latency: got %0d edges, want %0d", e, MUL_EDGES);
    end
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      errors++; $display("FAIL mult_result: hi=%h lo=%h, want FFFFFFFF FFFFFFF1", hi, lo);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_pulse: done=%b one cycle later, want 0", done);
    end
    $display("mult -3*5: edges=%0d hi=%h lo=%h", e, hi, lo);
  endtask

  task automatic test_multu;
    int e;
    int busy_cycles;
    issue(3'b001, 32'hFFFFFFFF, 32'h00000002);
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    e = 0;
    while (done !== 1'b1 && e < 200) begin
      @(posedge clk); #1;
      e++;
      if (busy === 1'b1 && done !== 1'b1) busy_cycles++;
    end
    checks++;
    if (busy_cycles !== MUL_EDGES) begin
      errors++; $display("FAIL multu_busy: busy for %0d cycles, want %0d", busy_cycles, MUL_EDGES);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL multu_handshake: busy=%b done=%b, want 0 1", busy, done);
    end
    checks++;
    if (hi !== 32'h00000001 || lo !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL multu_result: hi=%h lo=%h, want 00000001 FFFFFFFE", hi, lo);
    end
    $display("multu FFFFFFFF*2: busy_cycles=%0d hi=%h lo=%h", busy_cycles, hi, lo);
  endtask

  task automatic test_div;
    int e;
    issue(3'b010, 32'hFFFFFFF9, 32'h00000002);
    wait_done(e);
    checks++;
    if (e !== 33) begin
      errors++; $display("FAIL div_latency: got %0d edges, want 33", e);
    end
    checks++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL div_signed: hi=%h lo=%h, want FFFFFFFF FFFFFFFD", hi, lo);
    end
    $display("div -7/2: edges=%0d hi=%h lo=%h", e, hi, lo);
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    wait_done(e);
    checks++;
    if (lo !== 32'h80000000 || hi !== 32'h00000000 || div0 !== 1'b0) begin
      errors++; $display("FAIL div_overflow: hi=%h lo=%h div0=%b, want 00000000 80000000 0", hi, lo, div0);
    end
    $display("div 80000000/-1: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_div0;
    int e;
    issue(3'b100, 32'h12345678, 32'h0);
    checks++;
    if (hi !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mthi: hi=%h busy=%b done=%b, want 12345678 0 0", hi, busy, done);
    end
    issue(3'b101, 32'h9ABCDEF0, 32'h0);
    checks++;
    if (lo !== 32'h9ABCDEF0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mtlo: lo=%h busy=%b done=%b, want 9ABCDEF0 0 0", lo, busy, done);
    end
    issue(3'b011, 32'h00000007, 32'h00000000);
    wait_done(e);
    checks++;
    if (e !== 1 || div0 !== 1'b1) begin
      errors++; $display("FAIL div0_flag: edges=%0d div0=%b, want 1 1", e, div0);
    end
    checks++;
    if (hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
      errors++; $display("FAIL div0_hold: hi=%h lo=%h, want 12345678 9ABCDEF0", hi, lo);
    end
    $display("divu 7/0: edges=%0d div0=%b hi=%h lo=%h", e, div0, hi, lo);
    issue(3'b110, 32'hDEADBEEF, 32'h00000001);
    checks++;
    if (busy !== 1'b0 || div0 !== 1'b1 || hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
      errors++; $display("FAIL reserved_op: busy=%b div0=%b hi=%h lo=%h, want 0 1 unchanged", busy, div0, hi, lo);
    end
    issue(3'b011, 32'h00000007, 32'h00000002);
    checks++;
    if (div0 !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL div0_clear: div0=%b busy=%b, want 0 1", div0, busy);
    end
    wait_done(e);
    checks++;
    if (lo !== 32'h00000003 || hi !== 32'h00000001) begin
      errors++; $display("FAIL divu_result: hi=%h lo=%h, want 00000001 00000003", hi, lo);
    end
    $display("divu 7/2: edges=%0d hi=%h lo=%h", e, hi, lo);
  endtask

  task automatic test_back_to_back;
    int dones;
    logic [31:0] exp_hi, exp_lo;
`ifdef MDU_FAST_MULT_EN
    issue(3'b011, 32'd100, 32'd7);
    exp_hi = 32'd2; exp_lo = 32'd14;
`else
    issue(3'b001, 32'hFFFFFFFF, 32'h00000002);
    exp_hi = 32'h00000001; exp_lo = 32'hFFFFFFFE;
`endif
    dones = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 5 || cyc == 20) begin
        @(negedge clk);
        start = 1'b1; op = 3'b010; a = 32'h00000064; b = 32'h00000003;
        @(posedge clk); #1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 1) begin
      errors++; $display("FAIL ignore_dones: %0d done pulses, want 1", dones);
    end
    checks++;
    if (hi !== exp_hi || lo !== exp_lo) begin
      errors++; $display("FAIL ignore_result: hi=%h lo=%h, want %h %h", hi, lo, exp_hi, exp_lo);
    end
    $display("busy-ignore: dones=%0d hi=%h lo=%h", dones, hi, lo);
  endtask

  task automatic test_async_reset;
    int e;
    int dones;
    issue(3'b010, 32'hFFFFFFF9, 32'h00000002);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, div0} !== 3'b000 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL async_reset: busy=%b done=%b div0=%b hi=%h lo=%h, want all 0", busy, done, div0, hi, lo);
    end
    @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort: dones=%0d busy=%b after reset, want 0 0", dones, busy);
    end
    $display("async reset mid-div: dones=%0d busy=%b hi=%h lo=%h", dones, busy, hi, lo);
    issue(3'b000, 32'hFFFFFFFD, 32'h00000005);
    wait_done(e);
    checks++;
    if (e !== MUL_EDGES || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      errors++; $display("FAIL post_reset_mult: edges=%0d hi=%h lo=%h, want %0d FFFFFFFF FFFFFFF1", e, hi, lo, MUL_EDGES);
    end
    $display("mult after reset: edges=%0d hi=%h lo=%h", e, hi, lo);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div0();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
